// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
// MEM-stage controller for a 16-bit asynchronous SRAM. Each 32-bit load or
// store is performed as two half-word accesses (low half first), then padded
// with wait cycles so SRAM_freeze stays high for exactly ACCESS_CYCLES cycles.
// The freeze output stalls every pipeline register until the access is done.
//
// Parameters
//   BASE_ADDR      byte address that maps to SRAM word 0
//   ACCESS_CYCLES  freeze-high cycles per access, request cycle included (3..15)
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   wr_en, rd_en   store / load request, level-held until freeze drops
//   address        byte address (bits [1:0] ignored)
//   write_data     store data
//   read_data      registered load result, updated only by loads
//   SRAM_freeze    high while the pipeline must hold
//   SRAM_DQ        bidirectional SRAM data bus
//   SRAM_ADDR      SRAM half-word address {word, half}
//   SRAM_WE_N      write strobe, active low
//   SRAM_OE_N      output enable, active low
//   SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  permanently enabled (0)
// -----------------------------------------------------------------------------
module sram_ctrl #(
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned ACCESS_CYCLES = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        SRAM_freeze,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, DONE} state_t;

  state_t      state;
  logic        is_write;
  logic [15:0] wdata_hi;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic [3:0]  cnt;
  logic [16:0] wa;

  // Word index inside the SRAM; upper bits are dropped by the cast.
  assign wa = 17'((address - BASE_ADDR) >> 2);

  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  // Freeze must rise in the very cycle the request appears, so it is decoded
  // from the state and the live request rather than registered.
  assign SRAM_freeze = (state == LOW) || (state == HIGH) || (state == WAIT) ||
                       ((state == IDLE) && (wr_en || rd_en));

  // NOTE: strobes, address and bus drive are registered, so each is loaded on
  // the edge that enters the state in which it must be valid (one state early).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      wdata_hi  <= '0;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
      cnt       <= '0;
      read_data <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en || rd_en) begin
            // Write wins when both requests are present.
            is_write  <= wr_en;
            wdata_hi  <= write_data[31:16];
            SRAM_ADDR <= {wa, 1'b0};
            state     <= LOW;
            if (wr_en) begin
              SRAM_WE_N <= 1'b0;
              dq_oe     <= 1'b1;
              dq_out    <= write_data[15:0];
            end else begin
              SRAM_OE_N <= 1'b0;
            end
          end
        end
        LOW: begin
          SRAM_ADDR[0] <= 1'b1;
          if (is_write) dq_out <= wdata_hi;
          else          read_data[15:0] <= SRAM_DQ;
          state <= HIGH;
        end
        HIGH: begin
          if (!is_write) read_data[31:16] <= SRAM_DQ;
          SRAM_WE_N <= 1'b1;
          SRAM_OE_N <= 1'b1;
          dq_oe     <= 1'b0;
          if (ACCESS_CYCLES == 3) begin
            state <= DONE;
          end else begin
            cnt   <= 4'(ACCESS_CYCLES - 4);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= DONE;
          else             cnt   <= cnt - 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
// Directed bench for sram_ctrl. Two instances: ACCESS_CYCLES=6 and =3, each
// with its own behavioural SRAM. When neither strobe is active the model
// drives a keeper pattern (16'h5A5A) on the bus, so any stray drive from the
// controller shows up as a corrupted pattern in both 2- and 4-state simulation.
// -----------------------------------------------------------------------------
module tb_sram_ctrl;

  localparam logic [15:0] KEEP = 16'h5A5A;

  logic        clk;
  logic        rst;

  logic        wr_en6, rd_en6, wr_en3, rd_en3;
  logic [31:0] addr6, wdata6, addr3, wdata3;
  logic [31:0] rdata6, rdata3;
  logic        freeze6, freeze3;
  wire  [15:0] dq6, dq3;
  logic [17:0] a6, a3;
  logic        we6, oe6, ce6, ub6, lb6;
  logic        we3, oe3, ce3, ub3, lb3;

  logic [15:0] mem6 [0:262143];
  logic [15:0] mem3 [0:262143];

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Per-access observations filled by acc().
  int          fc, we_lo, oe_lo, n_ev, start_cyc, done_cyc;
  bit          bus_bad;
  logic [17:0] ev_addr [4];
  logic [15:0] ev_dq   [4];

  sram_ctrl #(.BASE_ADDR(1024), .ACCESS_CYCLES(6)) dut6 (
    .clk(clk), .rst(rst), .wr_en(wr_en6), .rd_en(rd_en6), .address(addr6),
    .write_data(wdata6), .read_data(rdata6), .SRAM_freeze(freeze6),
    .SRAM_DQ(dq6), .SRAM_ADDR(a6), .SRAM_WE_N(we6), .SRAM_OE_N(oe6),
    .SRAM_CE_N(ce6), .SRAM_UB_N(ub6), .SRAM_LB_N(lb6)
  );

  sram_ctrl #(.BASE_ADDR(1024), .ACCESS_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en3), .rd_en(rd_en3), .address(addr3),
    .write_data(wdata3), .read_data(rdata3), .SRAM_freeze(freeze3),
    .SRAM_DQ(dq3), .SRAM_ADDR(a3), .SRAM_WE_N(we3), .SRAM_OE_N(oe3),
    .SRAM_CE_N(ce3), .SRAM_UB_N(ub3), .SRAM_LB_N(lb3)
  );

  // SRAM models: read drive when OE low and WE high, keeper when idle,
  // released while the controller writes.
  assign dq6 = !we6 ? 16'hzzzz : (!oe6 ? mem6[a6] : KEEP);
  assign dq3 = !we3 ? 16'hzzzz : (!oe3 ? mem3[a3] : KEEP);

  always @(posedge clk) if (!we6) mem6[a6] <= dq6;
  always @(posedge clk) if (!we3) mem3[a3] <= dq3;

  always @(posedge clk) cyc <= cyc + 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access on the selected instance. Returns in the DONE cycle
  // (first freeze-low sample) with the requests dropped.
  task automatic acc(input bit use3, input logic wr, input logic rd,
                     input logic [31:0] a, input logic [31:0] wd);
    logic        f, w, o;
    logic [17:0] ad;
    logic [15:0] d;
    @(negedge clk);
    if (use3) begin wr_en3 = wr; rd_en3 = rd; addr3 = a; wdata3 = wd; end
    else      begin wr_en6 = wr; rd_en6 = rd; addr6 = a; wdata6 = wd; end
    fc = 0; we_lo = 0; oe_lo = 0; n_ev = 0; bus_bad = 1'b0;
    start_cyc = cyc;
    f = 1'b1;
    #1;
    for (int guard = 0; guard < 40; guard++) begin
      f  = use3 ? freeze3 : freeze6;
      w  = use3 ? we3 : we6;
      o  = use3 ? oe3 : oe6;
      ad = use3 ? a3 : a6;
      d  = use3 ? dq3 : dq6;
      if (!w && !o) begin
        bus_bad = 1'b1;
      end else if (!w || !o) begin
        if (!w) we_lo++; else oe_lo++;
        if (n_ev < 4) begin ev_addr[n_ev] = ad; ev_dq[n_ev] = d; end
        n_ev++;
      end else if (d !== KEEP) begin
        bus_bad = 1'b1;
      end
      if (!f) break;
      fc++;
      @(negedge clk);
      #1;
    end
    done_cyc = cyc;
    check("access_completes", {31'd0, f}, 32'd0);
    if (use3) begin wr_en3 = 1'b0; rd_en3 = 1'b0; end
    else      begin wr_en6 = 1'b0; rd_en6 = 1'b0; end
  endtask

  initial begin
    rst = 1'b1;
    wr_en6 = 1'b0; rd_en6 = 1'b0; addr6 = '0; wdata6 = '0;
    wr_en3 = 1'b0; rd_en3 = 1'b0; addr3 = '0; wdata3 = '0;

    // Reset state
    #2;
    check("rst_read_data", rdata6, 32'h0);
    check("rst_addr", {14'd0, a6}, 32'h0);
    check("rst_we_n", {31'd0, we6}, 32'd1);
    check("rst_oe_n", {31'd0, oe6}, 32'd1);
    check("rst_bus_released", {16'd0, dq6}, {16'd0, KEEP});
    check("rst_freeze", {31'd0, freeze6}, 32'd0);
    check("tied_enables", {29'd0, ce6, ub6, lb6}, 32'd0);
    check("rst_freeze_c3", {31'd0, freeze3}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: store 0xDEADBEEF @1024
    acc(1'b0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    check("t1_freeze_cycles", fc, 6);
    check("t1_freeze_low_cycle7", done_cyc - start_cyc, 6);
    check("t1_we_cycles", we_lo, 2);
    check("t1_oe_cycles", oe_lo, 0);
    check("t1_low_addr", {14'd0, ev_addr[0]}, 32'h0);
    check("t1_low_dq", {16'd0, ev_dq[0]}, 32'hBEEF);
    check("t1_high_addr", {14'd0, ev_addr[1]}, 32'h1);
    check("t1_high_dq", {16'd0, ev_dq[1]}, 32'hDEAD);
    check("t1_bus_idle", {31'd0, bus_bad}, 32'd0);
    check("t1_mem", {mem6[1], mem6[0]}, 32'hDEADBEEF);
    check("t1_read_data_kept", rdata6, 32'h0);

    // 2: load @1024
    acc(1'b0, 1'b0, 1'b1, 32'd1024, 32'h0);
    check("t2_freeze_cycles", fc, 6);
    check("t2_read_data", rdata6, 32'hDEADBEEF);
    check("t2_oe_cycles", oe_lo, 2);
    check("t2_we_cycles", we_lo, 0);
    check("t2_addrs", {7'd0, ev_addr[1][8:0], 7'd0, ev_addr[0][8:0]}, 32'h0001_0000);
    check("t2_bus", {31'd0, bus_bad}, 32'd0);

    // 3: store then load @1028, back to back
    acc(1'b0, 1'b1, 1'b0, 32'd1028, 32'hA5A50F0F);
    check("t3_store_freeze", fc, 6);
    check("t3_store_addr_lo", {14'd0, ev_addr[0]}, 32'h2);
    check("t3_store_addr_hi", {14'd0, ev_addr[1]}, 32'h3);
    begin
      int prev_done;
      prev_done = done_cyc;
      acc(1'b0, 1'b0, 1'b1, 32'd1028, 32'h0);
      check("t3_gap_one_cycle", start_cyc - prev_done, 1);
    end
    check("t3_load_freeze", fc, 6);
    check("t3_load_addr_lo", {14'd0, ev_addr[0]}, 32'h2);
    check("t3_read_data", rdata6, 32'hA5A50F0F);
    check("t3_bus", {31'd0, bus_bad}, 32'd0);

    // 6: both requests high -> store
    acc(1'b0, 1'b1, 1'b1, 32'd1032, 32'h12345678);
    check("t6_we_cycles", we_lo, 2);
    check("t6_oe_cycles", oe_lo, 0);
    check("t6_addr_lo", {14'd0, ev_addr[0]}, 32'h4);
    check("t6_mem", {mem6[5], mem6[4]}, 32'h12345678);
    check("t6_read_data_unchanged", rdata6, 32'hA5A50F0F);

    // 4: ACCESS_CYCLES=3, store then load @2044
    acc(1'b1, 1'b1, 1'b0, 32'd2044, 32'hF00DCAFE);
    check("t4_store_freeze", fc, 3);
    check("t4_store_addr_lo", {14'd0, ev_addr[0]}, 32'h1FE);
    check("t4_store_addr_hi", {14'd0, ev_addr[1]}, 32'h1FF);
    acc(1'b1, 1'b0, 1'b1, 32'd2044, 32'h0);
    check("t4_load_freeze", fc, 3);
    check("t4_no_wait", done_cyc - start_cyc, 3);
    check("t4_oe_cycles", oe_lo, 2);
    check("t4_read_data", rdata3, 32'hF00DCAFE);
    check("t4_bus", {31'd0, bus_bad}, 32'd0);

    // 5: reset during HIGH of a store @1036
    acc(1'b0, 1'b1, 1'b0, 32'd1036, 32'h22221111);
    @(negedge clk);
    wr_en6 = 1'b1; addr6 = 32'd1036; wdata6 = 32'hAAAA5555;
    @(negedge clk); #1;
    check("t5_low_dq", {16'd0, dq6}, 32'h5555);
    @(negedge clk); #1;
    check("t5_high_addr", {14'd0, a6}, 32'h7);
    check("t5_high_we_n", {31'd0, we6}, 32'd0);
    rst = 1'b1;
    wr_en6 = 1'b0;
    #1;
    check("t5_rst_we_n", {31'd0, we6}, 32'd1);
    check("t5_rst_oe_n", {31'd0, oe6}, 32'd1);
    check("t5_rst_bus", {16'd0, dq6}, {16'd0, KEEP});
    check("t5_rst_freeze", {31'd0, freeze6}, 32'd0);
    check("t5_rst_read_data", rdata6, 32'h0);
    check("t5_rst_addr", {14'd0, a6}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    acc(1'b0, 1'b0, 1'b1, 32'd1036, 32'h0);
    check("t5_load_freeze", fc, 6);
    check("t5_load_read_data", rdata6, 32'h22225555);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
